mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
// - MEM-stage data-memory access unit. Produces the aligned, sign/zero-extended load data that
//   writeback selects as memory_data.
// - Turns EX/MEM load/store controls into a req/ready/rvalid transaction on the data-memory port.
// - Holds the pipeline through multi-cycle memory latency.
// PARAMETERS
// - WORD_SIZE   32                   data width; byte-lane logic is fixed at 32
// - NUM_WORDS   1024                 data memory depth in words
// - ADDR_SIZE   $clog2(NUM_WORDS)    word-address width on the memory port
// PORTS
// - clk            in   1          system clock, rising edge
// - rst_n          in   1          asynchronous, active-low reset
// - mem_read       in   1          load request from EX/MEM
// - mem_write      in   1          store request from EX/MEM
// - funct3         in   3          000 B, 001 H, 010 W, 100 BU, 101 HU
// - alu_result     in   WORD_SIZE  byte address
// - store_data     in   WORD_SIZE  rs2 value for stores
// - stall          out  1          freeze upstream pipeline while high
// - mem_done       out  1          1-cycle pulse: access complete; load data valid
// - memory_data    out  WORD_SIZE  load result, extended, to writeback
// - misalign_fault out  1          1-cycle pulse: misaligned or illegal funct3; no access issued
// - dmem_req       out  1          memory request valid
// - dmem_we        out  1          1 = store, 0 = load
// - dmem_addr      out  ADDR_SIZE  word address = alu_result[ADDR_SIZE+1:2]; upper bits ignored (wrap)
// - dmem_be        out  4          byte enables (stores only; 0000 on loads)
// - dmem_wdata     out  WORD_SIZE  lane-replicated store data
// - dmem_ready     in   1          memory accepts request this cycle
// - dmem_rvalid    in   1          read data valid
// - dmem_rdata     in   WORD_SIZE  read data word
// BEHAVIOUR
// - Reset: state IDLE. All outputs 0, including memory_data and dmem_* outputs.
// - Priority: mem_write over mem_read. Both high executes the store only.
// - Alignment: H/HU needs addr[0]=0; W needs addr[1:0]=0. funct3 011/110/111 is illegal.
//   - A fault pulses misalign_fault in the next cycle.
//   - No dmem_req is issued; stall drops in that cycle; state returns to IDLE.
// - FSM IDLE -> REQ -> (load: WAIT) -> DONE -> IDLE.
// - IDLE: when mem_read|mem_write and the access is legal:
//   - stall goes high combinationally in the same cycle.
//   - addr, funct3, we, be and wdata are registered; inputs need not be held afterwards.
//   - Next state is REQ.
// - REQ: dmem_req=1.
//   - addr, we, be and wdata are held stable until the cycle dmem_ready=1.
//   - On ready: store goes to DONE; load goes to WAIT.
// - WAIT: dmem_req=0. On dmem_rvalid the word is captured:
//   - shifted right by 8*addr[1:0];
//   - B/H sign-extended, BU/HU zero-extended, W passed through;
//   - result lands in memory_data; next state is DONE.
//   - dmem_rvalid outside WAIT is ignored.
// - DONE: mem_done=1 and stall=0 for exactly 1 cycle, then IDLE.
//   - memory_data holds its value until the next load completes.
// - Stall: high in the accept cycle and in REQ/WAIT. Low in DONE and IDLE.
// - Minimum latency with ready and rvalid 1 cycle later: store mem_done at T+2, load at T+3.
//   T is the accept cycle.
// - Store lanes:
//   - SB: be = 1<<addr[1:0], wdata = {4{byte}}.
//   - SH: be = 0011 or 1100, wdata = {2{half}}.
//   - SW: be = 1111.
// - A new request seen in DONE is not accepted until IDLE; upstream is still stalled-then-released,
//   so it re-presents the request.
// - Reset mid-operation: immediate return to IDLE. dmem_req drops asynchronously; a pending
//   rvalid is discarded; memory_data is cleared.
// TESTING
// - SW 0xDEADBEEF @0x008, ready immediate -> dmem_addr=2, be=1111, wdata=0xDEADBEEF; mem_done at T+2.
// - LB @0x009, word 0xDEADBEEF -> memory_data=0xFFFFFFBE. LBU same address -> 0x000000BE.
// - LHU @0x00A -> 0x0000DEAD. LH @0x008 -> 0xFFFFBEEF. SB 0x5A @0x003 -> be=1000, wdata=0x5A5A5A5A.
// - LW @0x006 -> misalign_fault pulse at T+1; dmem_req never asserted; stall=0 from T+1.
// - dmem_ready held low 3 cycles -> stall stays high; dmem_addr, be and wdata are stable throughout.
// - rst_n low while in WAIT -> dmem_req=0, stall=0, memory_data=0; late rvalid has no effect.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: issues req/ready/rvalid transactions for loads and stores,
// stalls the pipeline through memory latency and returns aligned, extended load data.
module mem_access_unit #(
    parameter int unsigned WORD_SIZE = 32,
    parameter int unsigned NUM_WORDS = 1024,
    parameter int unsigned ADDR_SIZE = $clog2(NUM_WORDS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [2:0]           funct3,
    input  logic [WORD_SIZE-1:0] alu_result,
    input  logic [WORD_SIZE-1:0] store_data,
    output logic                 stall,
    output logic                 mem_done,
    output logic [WORD_SIZE-1:0] memory_data,
    output logic                 misalign_fault,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [ADDR_SIZE-1:0] dmem_addr,
    output logic [3:0]           dmem_be,
    output logic [WORD_SIZE-1:0] dmem_wdata,
    input  logic                 dmem_ready,
    input  logic                 dmem_rvalid,
    input  logic [WORD_SIZE-1:0] dmem_rdata
);

    typedef enum logic [2:0] {StIdle, StReq, StWait, StDone, StFault} state_e;

    state_e                 state_q, state_d;
    logic [ADDR_SIZE-1:0]   addr_q, addr_d;
    logic [1:0]             off_q, off_d;
    logic [2:0]             funct3_q, funct3_d;
    logic                   we_q, we_d;
    logic [3:0]             be_q, be_d;
    logic [WORD_SIZE-1:0]   wdata_q, wdata_d;
    logic [WORD_SIZE-1:0]   mdata_q, mdata_d;
    logic                   req_q, req_d;
    logic                   done_q, done_d;
    logic                   fault_q, fault_d;

    logic                   access;
    logic                   illegal;
    logic                   misaligned;
    logic [3:0]             be_new;
    logic [WORD_SIZE-1:0]   wdata_new;
    logic [WORD_SIZE-1:0]   shifted;
    logic [WORD_SIZE-1:0]   load_ext;

    // Word address wraps: bits above the memory depth are intentionally dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^alu_result[WORD_SIZE-1:ADDR_SIZE+2];

    assign access     = mem_read | mem_write;
    assign illegal    = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
    assign misaligned = ((funct3[1:0] == 2'b01) && alu_result[0]) ||
                        ((funct3[1:0] == 2'b10) && (alu_result[1:0] != 2'b00));

    always_comb begin
        be_new    = 4'b0000;
        wdata_new = '0;
        if (mem_write) begin
            unique case (funct3[1:0])
                2'b00: begin
                    be_new    = 4'b0001 << alu_result[1:0];
                    wdata_new = {4{store_data[7:0]}};
                end
                2'b01: begin
                    be_new    = alu_result[1] ? 4'b1100 : 4'b0011;
                    wdata_new = {2{store_data[15:0]}};
                end
                default: begin
                    be_new    = 4'b1111;
                    wdata_new = store_data;
                end
            endcase
        end
    end

    assign shifted = dmem_rdata >> {off_q, 3'b000};

    always_comb begin
        case (funct3_q)
            3'b000:  load_ext = {{(WORD_SIZE-8){shifted[7]}}, shifted[7:0]};
            3'b001:  load_ext = {{(WORD_SIZE-16){shifted[15]}}, shifted[15:0]};
            3'b100:  load_ext = {{(WORD_SIZE-8){1'b0}}, shifted[7:0]};
            3'b101:  load_ext = {{(WORD_SIZE-16){1'b0}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        off_d    = off_q;
        funct3_d = funct3_q;
        we_d     = we_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        mdata_d  = mdata_q;
        req_d    = 1'b0;
        done_d   = 1'b0;
        fault_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (access) begin
                    if (illegal || misaligned) begin
                        state_d = StFault;
                        fault_d = 1'b1;
                    end else begin
                        state_d  = StReq;
                        req_d    = 1'b1;
                        addr_d   = alu_result[ADDR_SIZE+1:2];
                        off_d    = alu_result[1:0];
                        funct3_d = funct3;
                        we_d     = mem_write;
                        be_d     = be_new;
                        wdata_d  = wdata_new;
                    end
                end
            end
            StReq: begin
                req_d = 1'b1;
                if (dmem_ready) begin
                    req_d = 1'b0;
                    if (we_q) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (dmem_rvalid) begin
                    mdata_d = load_ext;
                    state_d = StDone;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            off_q    <= '0;
            funct3_q <= '0;
            we_q     <= 1'b0;
            be_q     <= '0;
            wdata_q  <= '0;
            mdata_q  <= '0;
            req_q    <= 1'b0;
            done_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            off_q    <= off_d;
            funct3_q <= funct3_d;
            we_q     <= we_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            mdata_q  <= mdata_d;
            req_q    <= req_d;
            done_q   <= done_d;
            fault_q  <= fault_d;
        end
    end

    // Stall rises combinationally in the accept cycle so upstream freezes without a bubble.
    assign stall = ((state_q == StIdle) && access) || (state_q == StReq) || (state_q == StWait);

    assign mem_done       = done_q;
    assign misalign_fault = fault_q;
    assign memory_data    = mdata_q;
    assign dmem_req       = req_q;
    assign dmem_we        = we_q;
    assign dmem_addr      = addr_q;
    assign dmem_be        = be_q;
    assign dmem_wdata     = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: drives loads/stores/faults against a scripted memory and
// checks port activity cycle by cycle, with load results queued at issue and popped at mem_done.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] alu_result, store_data;
    logic        stall, mem_done, misalign_fault;
    logic [31:0] memory_data;
    logic        dmem_req, dmem_we;
    logic [9:0]  dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ready, dmem_rvalid;
    logic [31:0] dmem_rdata;

    int unsigned tests = 0;
    int unsigned fails = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    mem_access_unit #(.WORD_SIZE(32), .NUM_WORDS(1024)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .funct3         (funct3),
        .alu_result     (alu_result),
        .store_data     (store_data),
        .stall          (stall),
        .mem_done       (mem_done),
        .memory_data    (memory_data),
        .misalign_fault (misalign_fault),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_be        (dmem_be),
        .dmem_wdata     (dmem_wdata),
        .dmem_ready     (dmem_ready),
        .dmem_rvalid    (dmem_rvalid),
        .dmem_rdata     (dmem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_req(input string tag, input logic we, input logic [9:0] a,
                             input logic [3:0] be, input logic [31:0] wd);
        chk({tag, "_req"}, {31'b0, dmem_req}, 32'd1);
        chk({tag, "_stall"}, {31'b0, stall}, 32'd1);
        chk({tag, "_we"}, {31'b0, dmem_we}, {31'b0, we});
        chk({tag, "_addr"}, {22'b0, dmem_addr}, {22'b0, a});
        chk({tag, "_be"}, {28'b0, dmem_be}, {28'b0, be});
        chk({tag, "_wdata"}, dmem_wdata, wd);
    endtask

    // Called #1 after a rising edge; that cycle is the accept cycle T.
    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [31:0] rword,
                          input int ready_wait, input logic exp_fault,
                          input logic [9:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_data);
        logic [31:0] exp_v;
        logic is_load;
        is_load = rd && !wr;
        mem_read = rd; mem_write = wr; funct3 = f3; alu_result = addr; store_data = sdata;
        #1;
        chk({tag, "_stall_T"}, {31'b0, stall}, 32'd1);
        chk({tag, "_noreq_T"}, {31'b0, dmem_req}, 32'd0);
        if (!exp_fault && is_load) exp_q.push_back(exp_data);
        step();
        // Scramble the inputs: the unit must have captured everything it needs.
        mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b111;
        alu_result = 32'hFFFF_FFFF; store_data = ~sdata;
        #1;
        if (exp_fault) begin
            chk({tag, "_fault"}, {31'b0, misalign_fault}, 32'd1);
            chk({tag, "_fault_stall"}, {31'b0, stall}, 32'd0);
            chk({tag, "_fault_req"}, {31'b0, dmem_req}, 32'd0);
            step();
            chk({tag, "_fault_pulse"}, {31'b0, misalign_fault}, 32'd0);
            chk({tag, "_fault_req2"}, {31'b0, dmem_req}, 32'd0);
            return;
        end
        check_req(tag, wr, exp_addr, exp_be, exp_wdata);
        for (int i = 0; i < ready_wait; i++) begin
            step();
            check_req({tag, "_hold"}, wr, exp_addr, exp_be, exp_wdata);
        end
        dmem_ready = 1'b1;
        step();
        dmem_ready = 1'b0;
        if (is_load) begin
            chk({tag, "_wait_req"}, {31'b0, dmem_req}, 32'd0);
            chk({tag, "_wait_stall"}, {31'b0, stall}, 32'd1);
            chk({tag, "_wait_done"}, {31'b0, mem_done}, 32'd0);
            dmem_rvalid = 1'b1; dmem_rdata = rword;
            step();
            dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        end
        chk({tag, "_done"}, {31'b0, mem_done}, 32'd1);
        chk({tag, "_done_stall"}, {31'b0, stall}, 32'd0);
        if (is_load) begin
            if (exp_q.size() == 0) begin
                chk({tag, "_sb_empty"}, 32'd0, 32'd1);
            end else begin
                exp_v = exp_q.pop_front();
                chk({tag, "_data"}, memory_data, exp_v);
            end
        end
        step();
        chk({tag, "_done_pulse"}, {31'b0, mem_done}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
        alu_result = '0; store_data = '0; dmem_ready = 1'b0; dmem_rvalid = 1'b0;
        dmem_rdata = '0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_done", {31'b0, mem_done}, 32'd0);
        chk("rst_fault", {31'b0, misalign_fault}, 32'd0);
        chk("rst_mdata", memory_data, 32'd0);
        chk("rst_req", {31'b0, dmem_req}, 32'd0);
        chk("rst_we", {31'b0, dmem_we}, 32'd0);
        chk("rst_addr", {22'b0, dmem_addr}, 32'd0);
        chk("rst_be", {28'b0, dmem_be}, 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);

        //     tag      rd    wr    f3      addr          sdata         rword         rw fault addr   be       wdata         data
        access("sw",    1'b0, 1'b1, 3'b010, 32'h0000_0008, 32'hDEADBEEF, 32'h0,        0, 1'b0, 10'd2, 4'b1111, 32'hDEADBEEF, 32'h0);
        access("lb",    1'b1, 1'b0, 3'b000, 32'h0000_0009, 32'h0,        32'hDEADBEEF, 0, 1'b0, 10'd2, 4'b0000, 32'h0,        32'hFFFFFFBE);
        access("lbu",   1'b1, 1'b0, 3'b100, 32'h0000_0009, 32'h0,        32'hDEADBEEF, 0, 1'b0, 10'd2, 4'b0000, 32'h0,        32'h000000BE);
        access("lhu",   1'b1, 1'b0, 3'b101, 32'h0000_000A, 32'h0,        32'hDEADBEEF, 1, 1'b0, 10'd2, 4'b0000, 32'h0,        32'h0000DEAD);
        access("lh",    1'b1, 1'b0, 3'b001, 32'h0000_0008, 32'h0,        32'hDEADBEEF, 0, 1'b0, 10'd2, 4'b0000, 32'h0,        32'hFFFFBEEF);
        access("sb",    1'b0, 1'b1, 3'b000, 32'h0000_0003, 32'h0000005A, 32'h0,        0, 1'b0, 10'd0, 4'b1000, 32'h5A5A5A5A, 32'h0);
        chk("store_keeps_mdata", memory_data, 32'hFFFFBEEF);
        access("sh_rw", 1'b1, 1'b1, 3'b001, 32'h0000_0006, 32'hABCD1234, 32'h0,        3, 1'b0, 10'd1, 4'b1100, 32'h12341234, 32'h0);
        access("lw_mis",1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0,        32'h0,        0, 1'b1, 10'd0, 4'b0000, 32'h0,        32'h0);
        access("f3_ill",1'b1, 1'b0, 3'b011, 32'h0000_0000, 32'h0,        32'h0,        0, 1'b1, 10'd0, 4'b0000, 32'h0,        32'h0);
        chk("fault_keeps_mdata", memory_data, 32'hFFFFBEEF);
        access("lw_wrap",1'b1,1'b0, 3'b010, 32'h0000_1004, 32'h0,        32'hCAFEF00D, 2, 1'b0, 10'd1, 4'b0000, 32'h0,        32'hCAFEF00D);

        // Reset while a load sits in WAIT.
        mem_read = 1'b1; funct3 = 3'b010; alu_result = 32'h0000_0010;
        step();
        mem_read = 1'b0;
        dmem_ready = 1'b1;
        step();
        dmem_ready = 1'b0;
        chk("rstw_inwait_stall", {31'b0, stall}, 32'd1);
        chk("rstw_inwait_req", {31'b0, dmem_req}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rstw_req", {31'b0, dmem_req}, 32'd0);
        chk("rstw_stall", {31'b0, stall}, 32'd0);
        chk("rstw_mdata", memory_data, 32'd0);
        step();
        #2 rst_n = 1'b1;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
        step();
        dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        chk("rstw_late_done", {31'b0, mem_done}, 32'd0);
        chk("rstw_late_mdata", memory_data, 32'd0);
        chk("rstw_late_stall", {31'b0, stall}, 32'd0);
        step();
        chk("rstw_late_done2", {31'b0, mem_done}, 32'd0);
        chk("rstw_late_req", {31'b0, dmem_req}, 32'd0);
        chk("sb_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
